// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply sequencer.
//   - op encodings as presented by the EX stage
//   - FSM state enum
//   - default operand width / iteration count
package muldiv_pkg;

  localparam int MUL_ITERS = 32;  // one iteration per multiplier bit

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_MTHI  = 2'b10;
  localparam logic [1:0] OP_MTLO  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  // Multiplies are the ops with bit 1 clear.
  function automatic logic is_mul_op(input logic [1:0] op);
    return (op == OP_MULTU) || (op == OP_MULT);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_mul_shift_add.sv
// mul_shift_add: unsigned shift-add multiply datapath.
//   clk, reset     : clock, synchronous active-high reset
//   load           : capture mcand/mplier, clear accumulator
//   step           : one add-shift iteration
//   mcand, mplier  : unsigned WIDTH-bit operands
//   acc            : 2*WIDTH-bit running product
module mul_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   acc
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_addend;

  // Multiplicand is kept 2*WIDTH wide so it can be shifted left
  // without losing the high bits of the partial product.
  assign w_addend = r_mplier[0] ? r_mcand : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (load) begin
      r_mcand  <= {{WIDTH{1'b0}}, mcand};
      r_mplier <= mplier;
      r_acc    <= '0;
    end else if (step) begin
      r_acc    <= r_acc + w_addend;
      r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO sequencer. Runs a WIDTH-iteration shift-add multiply
// for MULT/MULTU, writes MTHI/MTLO directly, and owns the HI/LO registers.
//   clk, reset      : clock, synchronous active-high reset
//   start, op       : operation valid / code (sampled in IDLE only)
//   src_a, src_b    : rs (multiplicand or MTHI/MTLO data), rt (multiplier)
//   rd_req          : MFHI/MFLO in read stage
//   busy            : multiply in progress (CALC or WB)
//   stall           : rd_req & busy, combinational
//   done            : one-cycle pulse, new HI/LO visible
//   hi_out, lo_out  : architectural HI/LO
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MUL_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic                 w_accept;
  logic                 w_signed;
  logic                 w_step;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_acc;
  logic [2*WIDTH-1:0]   w_result;

  assign w_accept = (r_state == ST_IDLE) && start && is_mul_op(op);
  assign w_signed = (op == OP_MULT);
  assign w_step   = (r_state == ST_CALC);

  // Magnitudes for the signed case. The most negative value negates to
  // itself, which read as unsigned is exactly its magnitude.
  assign w_mag_a = (w_signed && src_a[WIDTH-1]) ? (~src_a + WIDTH'(1)) : src_a;
  assign w_mag_b = (w_signed && src_b[WIDTH-1]) ? (~src_b + WIDTH'(1)) : src_b;

  mul_shift_add #(.WIDTH(WIDTH)) u_msa (
    .clk    (clk),
    .reset  (reset),
    .load   (w_accept),
    .step   (w_step),
    .mcand  (w_mag_a),
    .mplier (w_mag_b),
    .acc    (w_acc)
  );

  assign w_result = r_neg ? (~w_acc + (2*WIDTH)'(1)) : w_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: r_hi <= src_a;
              OP_MTLO: r_lo <= src_a;
              default: begin
                r_state <= ST_CALC;
                r_cnt   <= '0;
                r_neg   <= w_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              end
            endcase
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) r_state <= ST_WB;
        end
        ST_WB: begin
          {r_hi, r_lo} <= w_result;
          r_done       <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign stall  = rd_req & busy;
  assign done   = r_done;
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_req;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .rd_req (rd_req),
    .busy   (busy),
    .stall  (stall),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue a multiply; expects 33 busy cycles then a done cycle with the result.
  // Returns in the done cycle so a following call issues back-to-back.
  task automatic do_mul(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input bit hold_rd, input bit poke);
    int cnt;
    start = 1'b1; op = o; src_a = a; src_b = b;
    rd_req = hold_rd;
    tick();
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 60) begin
      cnt++;
      chk({tag, "_done_lo"}, {63'd0, done}, 64'd0);
      chk({tag, "_hi_hold"}, {32'd0, hi_out}, {32'd0, m_hi});
      chk({tag, "_lo_hold"}, {32'd0, lo_out}, {32'd0, m_lo});
      if (hold_rd) chk({tag, "_stall"}, {63'd0, stall}, 64'd1);
      if (poke && cnt == 5) begin
        start = 1'b1; op = 2'b10; src_a = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'd33);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_stall_done"}, {63'd0, stall}, 64'd0);
    chk({tag, "_hi"}, {32'd0, hi_out}, {32'd0, ehi});
    chk({tag, "_lo"}, {32'd0, lo_out}, {32'd0, elo});
    m_hi = ehi; m_lo = elo;
    rd_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; rd_req = 1'b1;
    m_hi = '0; m_lo = '0;
    tick(); tick();
    chk("rst_busy",  {63'd0, busy},  64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_done",  {63'd0, done},  64'd0);
    chk("rst_hi",    {32'd0, hi_out}, 64'd0);
    chk("rst_lo",    {32'd0, lo_out}, 64'd0);
    reset = 1'b0; rd_req = 1'b0;
    tick();

    // Unsigned full-scale
    do_mul("multu_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    tick();
    chk("done_pulse_end", {63'd0, done}, 64'd0);

    // Signed cases
    do_mul("mult_m2x3", 2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0);
    tick();
    do_mul("mult_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    tick();

    // MTHI then MTLO on consecutive cycles
    start = 1'b1; op = 2'b10; src_a = 32'h12345678;
    tick();
    chk("mthi_hi",   {32'd0, hi_out}, 64'h12345678);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    op = 2'b11; src_a = 32'h9ABCDEF0;
    tick();
    start = 1'b0;
    chk("mtlo_lo",   {32'd0, lo_out}, 64'h9ABCDEF0);
    chk("mtlo_hi",   {32'd0, hi_out}, 64'h12345678);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("mt_done",   {63'd0, done}, 64'd0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;

    // rd_req held throughout, plus an MTHI poked in while busy
    do_mul("stall_poke", 2'b01, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h00000000, 32'h0000000C, 1'b1, 1'b1);
    tick();

    // Reset during CALC iteration 10
    start = 1'b1; op = 2'b00; src_a = 32'h11111111; src_b = 32'h22222222;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_hi",   {32'd0, hi_out}, 64'd0);
    chk("midrst_lo",   {32'd0, lo_out}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    m_hi = '0; m_lo = '0;
    repeat (3) begin
      tick();
      chk("midrst_nodone", {63'd0, done}, 64'd0);
      chk("midrst_idle",   {63'd0, busy}, 64'd0);
    end
    do_mul("multu_7x6", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0);
    tick();

    // Back-to-back: second multiply issued in the done cycle of the first
    do_mul("b2b_1", 2'b00, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780, 1'b0, 1'b0);
    do_mul("b2b_2", 2'b01, 32'd5, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0, 1'b0);
    tick();
    chk("b2b_done_end", {63'd0, done}, 64'd0);
    chk("b2b_hi_keep",  {32'd0, hi_out}, 64'hFFFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
